// File: rtl/cc_expun_queue_if.sv
// Expunge queue bus: per-way expunge inputs from the tag array, the
// head-of-queue handshake toward L2, and status/back-pressure outputs.
interface cc_expun_queue_if #(
  parameter int unsigned ADDR_W     = 37,
  parameter int unsigned DEPTH_BITS = 2
);
  logic [7:0]          exp_en;
  logic [8*ADDR_W-1:0] exp_addr;
  logic                out_en;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_ack;
  logic                stall;
  logic                multi_err;
  logic                ovf_err;
  logic [DEPTH_BITS:0] count;

  // Tag array / L2 side drives expunges and acks.
  modport master (
    output exp_en, exp_addr, out_ack,
    input  out_en, out_addr, stall, multi_err, ovf_err, count
  );

  // The queue itself.
  modport slave (
    input  exp_en, exp_addr, out_ack,
    output out_en, out_addr, stall, multi_err, ovf_err, count
  );
endinterface

// File: rtl/cc_expun_queue.sv
// Expunge (victim) address queue: picks one way's expunge address per cycle,
// merges back-to-back repeats of the same line, buffers in a small FIFO and
// presents the head to L2 with a registered valid/ack handshake.
// All state changes on the falling clock edge, matching the tag array.
module cc_expun_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_BITS = 2,
  parameter int unsigned ADDR_W     = 37
) (
  input logic             clk,
  input logic             rst,
  cc_expun_queue_if.slave bus
);

  localparam logic [DEPTH_BITS:0] CntFull  = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] CntStall = (DEPTH_BITS+1)'(DEPTH - 1);

  logic [ADDR_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] rd_q, rd_d, wr_q, wr_d, tail_ptr;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic                  out_en_q, out_en_d;
  logic [ADDR_W-1:0]     out_addr_q, out_addr_d;
  logic                  stall_q, stall_d;
  logic                  multi_q, ovf_q;

  logic                  push_req, multi_hit, merge, full, pop, push_acc, ovf_hit;
  logic [ADDR_W-1:0]     push_addr;

  // Way select: lowest-index enabled way wins; flag any multi-hot enable.
  always_comb begin
    push_addr = '0;
    for (int w = 7; w >= 0; w--) begin
      if (bus.exp_en[w]) push_addr = bus.exp_addr[w*ADDR_W +: ADDR_W];
    end
    push_req  = |bus.exp_en;
    multi_hit = (bus.exp_en & (bus.exp_en - 8'd1)) != 8'd0;
  end

  // Accept/drop decision and next pointer/count/output state.
  always_comb begin
    tail_ptr = wr_q - 1'b1;
    // Compare against the pre-pop tail so a same-edge pop cannot hide a repeat.
    merge    = (count_q != '0) && (push_addr == mem_q[tail_ptr]);
    full     = (count_q == CntFull);
    pop      = out_en_q && bus.out_ack;
    push_acc = push_req && !merge && (!full || pop);
    ovf_hit  = push_req && !merge && full && !pop;

    rd_d    = pop      ? rd_q + 1'b1 : rd_q;
    wr_d    = push_acc ? wr_q + 1'b1 : wr_q;
    count_d = count_q;
    if (push_acc && !pop)      count_d = count_q + 1'b1;
    else if (!push_acc && pop) count_d = count_q - 1'b1;

    out_en_d = (count_d != '0);
    // Bypass when the new head is the entry being written this edge.
    if (push_acc && (wr_q == rd_d)) out_addr_d = push_addr;
    else                            out_addr_d = mem_q[rd_d];
    stall_d = (count_d >= CntStall);
  end

  // FIFO storage; contents are don't-care after reset so no reset here.
  always_ff @(negedge clk) begin
    if (push_acc) mem_q[wr_q] <= push_addr;
  end

  // Control state, registered outputs and sticky error flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      out_en_q   <= 1'b0;
      out_addr_q <= '0;
      stall_q    <= 1'b0;
      multi_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      out_en_q   <= out_en_d;
      out_addr_q <= out_addr_d;
      stall_q    <= stall_d;
      multi_q    <= multi_q | multi_hit;
      ovf_q      <= ovf_q | ovf_hit;
    end
  end

  assign bus.out_en    = out_en_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.stall     = stall_q;
  assign bus.multi_err = multi_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_cc_expun_queue.sv
// Directed bench for cc_expun_queue. The DUT updates on the falling edge;
// inputs change and outputs are sampled 1 time unit after that edge.
module tb_cc_expun_queue;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned DEPTH_BITS = 2;
  localparam int unsigned ADDR_W     = 37;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cc_expun_queue_if #(.ADDR_W(ADDR_W), .DEPTH_BITS(DEPTH_BITS)) bus ();

  cc_expun_queue #(.DEPTH(DEPTH), .DEPTH_BITS(DEPTH_BITS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exp_en   = 8'h00;
    bus.exp_addr = '0;
    bus.out_ack  = 1'b0;
  endtask

  // One edge with a single-way expunge and optional ack.
  task automatic push(input int way, input logic [ADDR_W-1:0] a, input logic ack);
    bus.exp_addr = '0;
    bus.exp_addr[way*ADDR_W +: ADDR_W] = a;
    bus.exp_en  = 8'(1 << way);
    bus.out_ack = ack;
    tick();
    idle();
  endtask

  task automatic ack_one();
    bus.out_ack = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: out_en=%b count=%0d stall=%b, want 0 0 0",
               bus.out_en, bus.count, bus.stall);
    end
    checks++;
    if (bus.out_addr !== '0 || bus.multi_err !== 1'b0 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: out_addr=%h multi=%b ovf=%b, want 0 0 0",
               bus.out_addr, bus.multi_err, bus.ovf_err);
    end
  endtask

  task automatic test_basic_push();
    do_reset();
    push(2, 37'h1234, 1'b0);
    checks++;
    if (bus.out_en !== 1'b1 || bus.out_addr !== 37'h1234 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL basic_push: out_en=%b addr=%h count=%0d, want 1 1234 1",
               bus.out_en, bus.out_addr, bus.count);
    end
    tick();
    tick();
    checks++;
    if (bus.out_en !== 1'b1 || bus.out_addr !== 37'h1234) begin
      errors++;
      $display("FAIL basic_hold: out_en=%b addr=%h, want 1 1234", bus.out_en, bus.out_addr);
    end
    ack_one();
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL basic_pop: out_en=%b count=%0d, want 0 0", bus.out_en, bus.count);
    end
    // Ack with nothing valid must not underflow.
    ack_one();
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL ack_empty: out_en=%b count=%0d, want 0 0", bus.out_en, bus.count);
    end
  endtask

  task automatic test_fill_overflow_drain();
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       exp_stl [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(i % 8, 37'(i + 1), 1'b0);
      checks++;
      if (bus.count !== exp_cnt[i] || bus.stall !== exp_stl[i] || bus.ovf_err !== exp_ovf[i]) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d stall=%b ovf=%b, want %0d %b %b", i + 1,
                 bus.count, bus.stall, bus.ovf_err, exp_cnt[i], exp_stl[i], exp_ovf[i]);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (bus.out_en !== 1'b1 || bus.out_addr !== 37'(i)) begin
        errors++;
        $display("FAIL drain_%0d: out_en=%b addr=%h, want 1 %h", i, bus.out_en, bus.out_addr,
                 37'(i));
      end
      ack_one();
    end
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0 || bus.stall !== 1'b0 ||
        bus.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: out_en=%b count=%0d stall=%b ovf=%b, want 0 0 0 1",
               bus.out_en, bus.count, bus.stall, bus.ovf_err);
    end
  endtask

  task automatic test_multi_way();
    do_reset();
    bus.exp_addr = '0;
    bus.exp_addr[4*ADDR_W +: ADDR_W] = 37'hA;
    bus.exp_addr[5*ADDR_W +: ADDR_W] = 37'hB;
    bus.exp_en = 8'h30;
    tick();
    idle();
    checks++;
    if (bus.count !== 3'd1 || bus.out_addr !== 37'hA || bus.multi_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_push: count=%0d addr=%h multi=%b, want 1 a 1",
               bus.count, bus.out_addr, bus.multi_err);
    end
    ack_one();
    tick();
    checks++;
    if (bus.multi_err !== 1'b1 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL multi_sticky: multi=%b count=%0d, want 1 0", bus.multi_err, bus.count);
    end
    do_reset();
    checks++;
    if (bus.multi_err !== 1'b0) begin
      errors++;
      $display("FAIL multi_clear: multi=%b, want 0", bus.multi_err);
    end
  endtask

  task automatic test_merge();
    do_reset();
    push(0, 37'h77, 1'b0);
    push(0, 37'h77, 1'b0);
    checks++;
    if (bus.count !== 3'd1 || bus.out_addr !== 37'h77 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL merge: count=%0d addr=%h ovf=%b, want 1 77 0",
               bus.count, bus.out_addr, bus.ovf_err);
    end
    ack_one();
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0) begin
      errors++;
      $display("FAIL merge_drain: out_en=%b count=%0d, want 0 0", bus.out_en, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    // Push and pop on the same edge with one entry: new entry becomes head.
    do_reset();
    push(1, 37'h11, 1'b0);
    push(3, 37'h22, 1'b1);
    checks++;
    if (bus.count !== 3'd1 || bus.out_en !== 1'b1 || bus.out_addr !== 37'h22) begin
      errors++;
      $display("FAIL pushpop_one: count=%0d out_en=%b addr=%h, want 1 1 22",
               bus.count, bus.out_en, bus.out_addr);
    end
  endtask

  task automatic test_push_pop_full();
    logic [ADDR_W-1:0] exp_seq [4] = '{37'h2, 37'h3, 37'h4, 37'h9};
    do_reset();
    for (int i = 1; i <= 4; i++) push(i, 37'(i), 1'b0);
    push(6, 37'h9, 1'b1);
    checks++;
    if (bus.count !== 3'd4 || bus.out_addr !== 37'h2 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d addr=%h ovf=%b, want 4 2 0",
               bus.count, bus.out_addr, bus.ovf_err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_en !== 1'b1 || bus.out_addr !== exp_seq[i]) begin
        errors++;
        $display("FAIL full_drain_%0d: out_en=%b addr=%h, want 1 %h", i, bus.out_en,
                 bus.out_addr, exp_seq[i]);
      end
      ack_one();
    end
    checks++;
    if (bus.out_en !== 1'b0) begin
      errors++;
      $display("FAIL full_drain_end: out_en=%b, want 0", bus.out_en);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) push(0, 37'(i + 16), 1'b0);
    ack_one();
    ack_one();
    checks++;
    if (bus.count !== 3'd2 || bus.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: count=%0d ovf=%b, want 2 1", bus.count, bus.ovf_err);
    end
    do_reset();
    checks++;
    if (bus.out_en !== 1'b0 || bus.count !== 3'd0 || bus.stall !== 1'b0 ||
        bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_en=%b count=%0d stall=%b ovf=%b, want 0 0 0 0",
               bus.out_en, bus.count, bus.stall, bus.ovf_err);
    end
    push(7, 37'h5, 1'b0);
    checks++;
    if (bus.out_en !== 1'b1 || bus.out_addr !== 37'h5 || bus.count !== 3'd1) begin
      errors++;
      $display("FAIL mid_repush: out_en=%b addr=%h count=%0d, want 1 5 1",
               bus.out_en, bus.out_addr, bus.count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_basic_push();
    test_fill_overflow_drain();
    test_multi_way();
    test_merge();
    test_back_to_back();
    test_push_pop_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cc_expun_queue.md
Name: cc_expun_queue

Overview:
- Collects cache-line expunge (victim) addresses from the 8 ways of the instruction-cache tag array and buffers them in a FIFO.
- Forwards them one at a time to the L2/coherence interface using a valid/ack handshake.
- Sits directly downstream of the per-way tag blocks and consumes their expunge-address and expunge-enable outputs.
- Back-pressures the refill/write path through an almost-full stall.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- DEPTH_BITS, 2: log2(DEPTH).
- ADDR_W, 37: expunge line-address width (physical address bits 43:7).

Ports:
- clk  in  1  clock; all state updates on falling edge, same as the tag array.
- rst  in  1  synchronous active-high reset.
- exp_en  in  8  per-way expunge enable; at most one bit is expected high per cycle.
- exp_addr  in  8*ADDR_W  per-way expunge line address; way w occupies bits [w*ADDR_W +: ADDR_W].
- out_en  out  1  head entry valid toward L2.
- out_addr  out  ADDR_W  head entry address.
- out_ack  in  1  L2 consumes the head entry on an edge where out_en && out_ack.
- stall  out  1  almost-full; the write path must not start a new tag write.
- multi_err  out  1  sticky flag: more than one exp_en bit was high in one cycle.
- ovf_err  out  1  sticky flag: a push was dropped because the FIFO was full.
- count  out  DEPTH_BITS+1  current occupancy.

Behaviour:
- Reset values (rst high at an edge):
  - rd_ptr = wr_ptr = 0, count = 0.
  - out_en = 0, out_addr = 0, stall = 0, multi_err = 0, ovf_err = 0.
  - FIFO contents are don't-care.
- Way select (combinational):
  - push_req = |exp_en.
  - push_addr = address of the lowest-index set bit.
  - If popcount(exp_en) > 1, multi_err is set at that edge and stays set until reset; the lowest-index way is still pushed.
- Merge rule: a push is dropped with no error when count != 0 and push_addr equals the most recently written entry (entry wr_ptr-1).
  - This absorbs a repeat expunge of the same line on back-to-back cycles.
- Pop: pop = out_en && out_ack.
  - rd_ptr increments mod DEPTH; count decrements.
- Push, when accepted: entry[wr_ptr] <= push_addr; wr_ptr increments mod DEPTH; count increments.
- Full (count == DEPTH):
  - Push with a simultaneous pop is accepted; count stays at DEPTH.
  - Push without a pop is dropped and ovf_err is set (sticky).
- Simultaneous push and pop at count == 1:
  - Head is popped and the new entry becomes head the next cycle; count stays 1.
  - The merge compare uses the pre-pop tail entry.
- Output registering:
  - out_en and out_addr are registered.
  - out_en = (next count != 0); out_addr = entry[next rd_ptr], or push_addr when that entry is being written in the same edge.
  - Push-to-out_en latency: 1 edge into an empty queue.
  - out_addr holds stable while out_en && !out_ack.
- stall is registered: stall = (next count >= DEPTH-1). This one-entry margin covers the tag pipeline's 1-cycle write latency.
- Pointers wrap naturally at DEPTH; count is the only full/empty discriminator.
- Reset mid-operation: all entries are discarded, out_en drops at that edge, and sticky errors clear.
- out_ack while out_en = 0 is ignored.

Test Plan:
- Basic push:
  - Stimulus: reset; exp_en=8'h04, way2 addr=37'h1234 for one cycle; out_ack=0.
  - Response: next edge out_en=1, out_addr=37'h1234, count=1; held until out_ack=1, then out_en=0, count=0.
- Fill, overflow, drain:
  - Stimulus: push distinct addrs 1,2,3,4,5 on consecutive cycles with out_ack=0.
  - Response: stall=1 after the 3rd push; count=4; addr 5 is dropped and ovf_err=1.
  - Drain with out_ack=1: out_addr sequence 1,2,3,4, then out_en=0.
- Multi-way error:
  - Stimulus: exp_en=8'h30, way4=37'hA, way5=37'hB.
  - Response: 37'hA is enqueued, multi_err=1 and stays 1 until rst.
- Merge:
  - Stimulus: exp_en=8'h01 with addr 37'h77 on two consecutive cycles.
  - Response: count=1; a single out_addr=37'h77 is delivered.
- Simultaneous push and pop at full:
  - Stimulus: queue holds 1,2,3,4; out_ack=1 and push 9 on the same edge.
  - Response: count stays 4; out_addr=2; ovf_err=0; later drain gives 2,3,4,9.
- Reset mid-operation:
  - Stimulus: queue holds 2 entries with ovf_err=1; rst=1 for one edge.
  - Response: out_en=0, count=0, stall=0, ovf_err=0; a subsequent push of 37'h5 appears as the head after 1 edge.
